// File: rtl/blur_stream_driver_pkg.sv
// Shared types and widths for the blur stream driver and the blur engine it feeds.
package blur_stream_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int RGB_W   = 24;
  localparam int PIX_W   = 25;
  localparam int RES_W   = 32;
  localparam int SOF_BIT = 24;

endpackage

// File: rtl/blur_stream_driver_if.sv
// Bus bundle between the driver and its pixel memory, blur engine and result memory.
interface blur_stream_driver_if #(
  parameter int ADDR_W = 16
);
  import blur_stream_driver_pkg::*;

  logic              o_mem_ren;
  logic [ADDR_W-1:0] o_mem_raddr;
  logic [RGB_W-1:0]  i_mem_rdata;

  logic              o_rgb_vld;
  logic [PIX_W-1:0]  o_rgb_data;
  logic              i_rgb_busy;

  logic              i_result_vld;
  logic [RES_W-1:0]  i_result_data;
  logic              o_result_busy;

  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [RES_W-1:0]  o_wr_data;

  modport master (
    output o_mem_ren, o_mem_raddr, o_rgb_vld, o_rgb_data,
           o_result_busy, o_wr_en, o_wr_addr, o_wr_data,
    input  i_mem_rdata, i_rgb_busy, i_result_vld, i_result_data
  );

  modport slave (
    input  o_mem_ren, o_mem_raddr, o_rgb_vld, o_rgb_data,
           o_result_busy, o_wr_en, o_wr_addr, o_wr_data,
    output i_mem_rdata, i_rgb_busy, i_result_vld, i_result_data
  );

endinterface

// File: rtl/blur_prefetch_fifo.sv
// Two-entry prefetch FIFO holding source pixels between memory and the blur stream.
module blur_prefetch_fifo
  import blur_stream_driver_pkg::*;
#(
  parameter int WIDTH = RGB_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is not reset; only the pointers and count define validity, and
  // consumers never look at head while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/blur_stream_driver.sv
// Streams a frame of source pixels into the blur engine and writes its results back.
module blur_stream_driver
  import blur_stream_driver_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int ADDR_W = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic          o_done,
  output logic          o_busy,
  blur_stream_driver_if.master bus
);

  localparam int N     = IMG_W * IMG_H;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  RD_END = CNT_W'(N);
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(N - 1);

  state_e            state, state_nx;
  logic [CNT_W-1:0]  rd_cnt;
  logic [ADDR_W-1:0] pix_cnt;
  logic [ADDR_W-1:0] res_cnt;
  logic              in_flight;

  logic              fifo_push, fifo_full, fifo_empty;
  logic [1:0]        fifo_count;
  logic [RGB_W-1:0]  fifo_head;

  logic              start_frame;
  logic              pix_xfer, res_xfer;
  logic              pix_last, res_last;
  logic [2:0]        committed;

  assign start_frame = (state == ST_IDLE) && i_start;
  assign pix_xfer    = bus.o_rgb_vld && !bus.i_rgb_busy;
  assign res_xfer    = bus.i_result_vld && !bus.o_result_busy;
  assign pix_last    = (pix_cnt == LAST);
  assign res_last    = (res_cnt == LAST);

  // Slots committed after this edge: the head leaving this cycle frees its slot,
  // which is what lets a full-rate stream keep one read in flight every cycle.
  assign committed     = 3'(fifo_count) + 3'(in_flight) - 3'(pix_xfer);
  assign bus.o_mem_ren = (state == ST_RUN) && (rd_cnt != RD_END) && (committed < 3'd2);
  assign bus.o_mem_raddr = rd_cnt[ADDR_W-1:0];

  assign fifo_push = in_flight && (!fifo_full || pix_xfer);

  blur_prefetch_fifo #(.WIDTH(RGB_W)) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (fifo_push),
    .push_data (bus.i_mem_rdata),
    .pop       (pix_xfer),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.o_rgb_vld = !fifo_empty;

  always_comb begin
    bus.o_rgb_data = '0;
    if (!fifo_empty) begin
      bus.o_rgb_data[SOF_BIT]     = (pix_cnt == '0);
      bus.o_rgb_data[RGB_W-1:0]   = fifo_head;
    end
  end

  assign bus.o_wr_en   = res_xfer;
  assign bus.o_wr_addr = res_xfer ? res_cnt : '0;
  assign bus.o_wr_data = res_xfer ? bus.i_result_data : '0;

  // NOTE: state and counters use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      rd_cnt    <= '0;
      pix_cnt   <= '0;
      res_cnt   <= '0;
      in_flight <= 1'b0;
    end else begin
      state     <= state_nx;
      in_flight <= bus.o_mem_ren;
      if (start_frame) begin
        rd_cnt  <= '0;
        pix_cnt <= '0;
        res_cnt <= '0;
      end else begin
        if (bus.o_mem_ren)         rd_cnt  <= rd_cnt + 1'b1;
        if (pix_xfer && !pix_last) pix_cnt <= pix_cnt + 1'b1;
        if (res_xfer && !res_last) res_cnt <= res_cnt + 1'b1;
      end
    end
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    state_nx          = state;
    o_done            = 1'b0;
    o_busy            = 1'b1;
    bus.o_result_busy = 1'b1;
    case (state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_nx = ST_RUN;
      end
      ST_RUN: begin
        bus.o_result_busy = 1'b0;
        if (pix_xfer && pix_last)
          state_nx = (res_xfer && res_last) ? ST_DONE : ST_DRAIN;
      end
      ST_DRAIN: begin
        bus.o_result_busy = 1'b0;
        if (res_xfer && res_last) state_nx = ST_DONE;
      end
      ST_DONE: begin
        o_done   = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_blur_stream_driver.sv
// Randomized bench: memory and blur models around the driver, checked against a frame-level model.
module tb_blur_stream_driver;
  import blur_stream_driver_pkg::*;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int ADDR_W = 16;
  localparam int N      = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic done, busy;

  blur_stream_driver_if #(.ADDR_W(ADDR_W)) bus ();

  blur_stream_driver #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .o_done  (done),
    .o_busy  (busy),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [RGB_W-1:0] src [N];
  int   busy_mode = 0;   // 0 idle, 1 toggle, 2 random, 3 held
  int   lat = 3;
  logic lat0 = 1'b0;
  logic drv_busy = 1'b0;
  logic drv_vld = 1'b0;
  logic [RES_W-1:0] drv_data = '0;

  typedef struct {
    logic [RGB_W-1:0] rgb;
    int               idx;
    int               due;
  } blur_t;
  blur_t blur_q[$];
  int    blur_cnt = 0;

  logic [PIX_W-1:0]        pix_seen[$];
  int                      pix_cyc[$];
  logic [ADDR_W+RES_W-1:0] wr_seen[$];
  int   done_cnt = 0, done_cyc = -1, reads = 0, first_vld = -1, start_cyc = 0;
  logic prev_stall = 1'b0;
  logic [PIX_W-1:0] prev_data = '0;

  assign bus.i_rgb_busy    = drv_busy;
  assign bus.i_result_vld  = lat0 ? (bus.o_rgb_vld & ~drv_busy) : drv_vld;
  assign bus.i_result_data = lat0 ? {8'(blur_cnt), bus.o_rgb_data[RGB_W-1:0]} : drv_data;

  // Source memory: one-cycle read latency, garbage when not reading.
  always @(posedge clk)
    bus.i_mem_rdata <= bus.o_mem_ren ? src[bus.o_mem_raddr[2:0]] : 24'($urandom);

  // Input driver, updated just after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    case (busy_mode)
      0:       drv_busy = 1'b0;
      1:       drv_busy = ~drv_busy;
      2:       drv_busy = 1'($urandom_range(0, 1));
      default: drv_busy = 1'b1;
    endcase
    if (blur_q.size() > 0 && blur_q[0].due <= cyc) begin
      drv_vld  = 1'b1;
      drv_data = {8'(blur_q[0].idx), blur_q[0].rgb};
    end else begin
      drv_vld = 1'b0;
    end
  end

  // Mid-cycle monitor: records what transfers on the coming edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        compared++;
        if (bus.o_rgb_vld !== 1'b1 || bus.o_rgb_data !== prev_data) begin
          mismatched++;
          $display("FAIL hold_stable: vld=%b data=%h required vld=1 data=%h",
                   bus.o_rgb_vld, bus.o_rgb_data, prev_data);
        end
      end
      prev_stall = bus.o_rgb_vld && drv_busy;
      prev_data  = bus.o_rgb_data;
      if (bus.o_mem_ren) reads++;
      if (bus.o_wr_en) wr_seen.push_back({bus.o_wr_addr, bus.o_wr_data});
      if (!lat0 && bus.i_result_vld && !bus.o_result_busy && blur_q.size() > 0)
        void'(blur_q.pop_front());
      if (bus.o_rgb_vld && first_vld < 0) first_vld = cyc;
      if (bus.o_rgb_vld && !drv_busy) begin
        pix_seen.push_back(bus.o_rgb_data);
        pix_cyc.push_back(cyc);
        if (!lat0) blur_q.push_back('{rgb: bus.o_rgb_data[RGB_W-1:0], idx: blur_cnt, due: cyc + lat});
        blur_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Frame-level reference model.
  function automatic logic [PIX_W-1:0] model_pix(int i);
    return {1'(i == 0), src[i]};
  endfunction

  function automatic logic [ADDR_W+RES_W-1:0] model_wr(int i);
    return {16'(i), 8'(i), src[i]};
  endfunction

  task automatic new_frame();
    pix_seen.delete(); pix_cyc.delete(); wr_seen.delete(); blur_q.delete();
    blur_cnt = 0; done_cnt = 0; done_cyc = -1; reads = 0; first_vld = -1;
    for (int i = 0; i < N; i++) src[i] = 24'($urandom);
  endtask

  task automatic pulse_start();
    @(posedge clk); #2;
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_pixels(input int n, input string name);
    int k = 0;
    while (pix_seen.size() < n && k < 200) begin
      @(posedge clk); #3;
      k++;
    end
    if (pix_seen.size() < n) begin
      compared++; mismatched++;
      $display("FAIL %s_pix_timeout: got %0d pixels required %0d", name, pix_seen.size(), n);
    end
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (done_cnt == 0 && k < 300) begin
      @(posedge clk); #3;
      k++;
    end
    repeat (4) @(posedge clk);
    #3;
    if (done_cnt == 0) begin
      compared++; mismatched++;
      $display("FAIL %s_done_timeout: no o_done within 300 cycles, required 1 pulse", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    compared++;
    if ({bus.o_rgb_vld, bus.o_mem_ren, bus.o_wr_en, done, busy, bus.o_result_busy} !== 6'b000001) begin
      mismatched++;
      $display("FAIL reset_ctrl: vld/ren/wr/done/busy/rbusy=%b required 000001",
               {bus.o_rgb_vld, bus.o_mem_ren, bus.o_wr_en, done, busy, bus.o_result_busy});
    end
    compared++;
    if ({bus.o_rgb_data, bus.o_mem_raddr, bus.o_wr_addr, bus.o_wr_data} !== '0) begin
      mismatched++;
      $display("FAIL reset_bus: rgb=%h raddr=%h waddr=%h wdata=%h required all 0",
               bus.o_rgb_data, bus.o_mem_raddr, bus.o_wr_addr, bus.o_wr_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    busy_mode = 0; lat = 3; lat0 = 1'b0;
    new_frame();
    pulse_start();
    wait_done("stream");
    compared++;
    if (first_vld !== start_cyc + 3) begin
      mismatched++;
      $display("FAIL stream_latency: first vld at cycle %0d required %0d", first_vld, start_cyc + 3);
    end
    compared++;
    if (pix_cyc.size() != N || pix_cyc[N-1] - pix_cyc[0] != N - 1) begin
      mismatched++;
      $display("FAIL stream_rate: %0d pixels, span %0d cycles required %0d pixels span %0d",
               pix_cyc.size(), pix_cyc.size() > 0 ? pix_cyc[pix_cyc.size()-1] - pix_cyc[0] : -1, N, N - 1);
    end
    for (int i = 0; i < N && i < pix_seen.size(); i++) begin
      compared++;
      if (pix_seen[i] !== model_pix(i)) begin
        mismatched++;
        $display("FAIL stream_pix%0d: got %h required %h", i, pix_seen[i], model_pix(i));
      end
    end
    for (int i = 0; i < N && i < wr_seen.size(); i++) begin
      compared++;
      if (wr_seen[i] !== model_wr(i)) begin
        mismatched++;
        $display("FAIL stream_wr%0d: got %h required %h", i, wr_seen[i], model_wr(i));
      end
    end
    compared++;
    if (wr_seen.size() != N || done_cnt != 1) begin
      mismatched++;
      $display("FAIL stream_counts: writes=%0d done=%0d required %0d and 1", wr_seen.size(), done_cnt, N);
    end
  endtask

  task automatic test_busy_toggle();
    busy_mode = 1; lat = 2; lat0 = 1'b0;
    new_frame();
    pulse_start();
    wait_done("toggle");
    busy_mode = 0;
    compared++;
    if (pix_seen.size() != N || wr_seen.size() != N || done_cnt != 1) begin
      mismatched++;
      $display("FAIL toggle_counts: pix=%0d writes=%0d done=%0d required %0d %0d 1",
               pix_seen.size(), wr_seen.size(), done_cnt, N, N);
    end
    for (int i = 0; i < N && i < pix_seen.size(); i++) begin
      compared++;
      if (pix_seen[i] !== model_pix(i)) begin
        mismatched++;
        $display("FAIL toggle_pix%0d: got %h required %h", i, pix_seen[i], model_pix(i));
      end
    end
    for (int i = 0; i < N && i < wr_seen.size(); i++) begin
      compared++;
      if (wr_seen[i] !== model_wr(i)) begin
        mismatched++;
        $display("FAIL toggle_wr%0d: got %h required %h", i, wr_seen[i], model_wr(i));
      end
    end
  endtask

  task automatic test_busy_hold();
    busy_mode = 0; lat = 3; lat0 = 1'b0;
    new_frame();
    pulse_start();
    wait_pixels(3, "hold");
    busy_mode = 3;
    repeat (10) @(posedge clk);
    #3;
    compared++;
    if (reads != pix_seen.size() + 2 || bus.o_mem_ren !== 1'b0) begin
      mismatched++;
      $display("FAIL hold_prefetch: reads=%0d ren=%b after %0d pixels required reads=%0d ren=0",
               reads, bus.o_mem_ren, pix_seen.size(), pix_seen.size() + 2);
    end
    busy_mode = 0;
    wait_done("hold");
    compared++;
    if (pix_seen.size() != N || reads != N || done_cnt != 1) begin
      mismatched++;
      $display("FAIL hold_counts: pix=%0d reads=%0d done=%0d required %0d %0d 1",
               pix_seen.size(), reads, done_cnt, N, N);
    end
    for (int i = 0; i < N && i < pix_seen.size(); i++) begin
      compared++;
      if (pix_seen[i] !== model_pix(i)) begin
        mismatched++;
        $display("FAIL hold_pix%0d: got %h required %h", i, pix_seen[i], model_pix(i));
      end
    end
  endtask

  task automatic test_start_ignored();
    busy_mode = 0; lat = 3; lat0 = 1'b0;
    new_frame();
    pulse_start();
    wait_pixels(2, "restart");
    pulse_start();
    wait_done("restart");
    repeat (20) @(posedge clk);
    #3;
    compared++;
    if (pix_seen.size() != N || wr_seen.size() != N || done_cnt != 1 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL restart_counts: pix=%0d writes=%0d done=%0d busy=%b required %0d %0d 1 0",
               pix_seen.size(), wr_seen.size(), done_cnt, busy, N, N);
    end
    for (int i = 0; i < N && i < wr_seen.size(); i++) begin
      compared++;
      if (wr_seen[i] !== model_wr(i)) begin
        mismatched++;
        $display("FAIL restart_wr%0d: got %h required %h", i, wr_seen[i], model_wr(i));
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    busy_mode = 0; lat = 3; lat0 = 1'b0;
    new_frame();
    pulse_start();
    wait_pixels(4, "midrst");
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    compared++;
    if ({bus.o_rgb_vld, bus.o_mem_ren, bus.o_wr_en, done, busy, bus.o_result_busy} !== 6'b000001) begin
      mismatched++;
      $display("FAIL midrst_ctrl: vld/ren/wr/done/busy/rbusy=%b required 000001",
               {bus.o_rgb_vld, bus.o_mem_ren, bus.o_wr_en, done, busy, bus.o_result_busy});
    end
    compared++;
    if ({bus.o_rgb_data, bus.o_mem_raddr, bus.o_wr_addr, bus.o_wr_data} !== '0) begin
      mismatched++;
      $display("FAIL midrst_bus: rgb=%h raddr=%h waddr=%h wdata=%h required all 0",
               bus.o_rgb_data, bus.o_mem_raddr, bus.o_wr_addr, bus.o_wr_data);
    end
    repeat (2) @(posedge clk);
    new_frame();
    #2;
    rst = 1'b0;
    pulse_start();
    wait_done("midrst");
    compared++;
    if (pix_seen.size() != N || wr_seen.size() != N || done_cnt != 1) begin
      mismatched++;
      $display("FAIL midrst_counts: pix=%0d writes=%0d done=%0d required %0d %0d 1",
               pix_seen.size(), wr_seen.size(), done_cnt, N, N);
    end
    for (int i = 0; i < N && i < pix_seen.size(); i++) begin
      compared++;
      if (pix_seen[i] !== model_pix(i)) begin
        mismatched++;
        $display("FAIL midrst_pix%0d: got %h required %h", i, pix_seen[i], model_pix(i));
      end
    end
  endtask

  task automatic test_same_cycle_done();
    busy_mode = 2; lat0 = 1'b1;
    new_frame();
    pulse_start();
    wait_done("samecyc");
    busy_mode = 0;
    compared++;
    if (done_cnt != 1 || pix_cyc.size() != N || done_cyc != pix_cyc[pix_cyc.size()-1] + 1) begin
      mismatched++;
      $display("FAIL samecyc_done: done=%0d at cycle %0d, pixels=%0d required 1 pulse one cycle after last pixel",
               done_cnt, done_cyc, pix_cyc.size());
    end
    for (int i = 0; i < N && i < wr_seen.size(); i++) begin
      compared++;
      if (wr_seen[i] !== model_wr(i)) begin
        mismatched++;
        $display("FAIL samecyc_wr%0d: got %h required %h", i, wr_seen[i], model_wr(i));
      end
    end
    lat0 = 1'b0;
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      busy_mode = 2; lat = int'($urandom_range(1, 5)); lat0 = 1'b0;
      new_frame();
      pulse_start();
      wait_done("random");
      busy_mode = 0;
      compared++;
      if (pix_seen.size() != N || wr_seen.size() != N || done_cnt != 1) begin
        mismatched++;
        $display("FAIL random%0d_counts: pix=%0d writes=%0d done=%0d required %0d %0d 1",
                 f, pix_seen.size(), wr_seen.size(), done_cnt, N, N);
      end
      for (int i = 0; i < N && i < pix_seen.size() && i < wr_seen.size(); i++) begin
        compared++;
        if (pix_seen[i] !== model_pix(i) || wr_seen[i] !== model_wr(i)) begin
          mismatched++;
          $display("FAIL random%0d_item%0d: pix=%h wr=%h required pix=%h wr=%h",
                   f, i, pix_seen[i], wr_seen[i], model_pix(i), model_wr(i));
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) src[i] = '0;
    test_reset();
    test_stream();
    test_busy_toggle();
    test_busy_hold();
    test_start_ignored();
    test_reset_mid_frame();
    test_same_cycle_done();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/blur_stream_driver.md
BLUR_STREAM_DRIVER -- requirements
Module: blur_stream_driver

Interface
REQ-001 SHALL have parameter IMG_W, default 8: image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 8: image height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 16: address width, with IMG_W*IMG_H <= 2**ADDR_W.
REQ-004 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 i_rst  in  1  asynchronous, active-high reset.
REQ-006 i_start  in  1  one-cycle pulse that begins one frame; sampled only in IDLE.
REQ-007 o_done  out  1  one-cycle pulse when the last result has been written.
REQ-008 o_busy  out  1  high in every state except IDLE.
REQ-009 o_mem_ren / o_mem_raddr  out  1/ADDR_W  source pixel read request; read data returns exactly 1 cycle later.
REQ-010 i_mem_rdata  in  24  source pixel {R,G,B}.
REQ-011 o_rgb_vld / o_rgb_data  out  1/25  pixel stream to the blur; o_rgb_data = {sof, R, G, B}.
REQ-012 i_rgb_busy  in  1  blur cannot accept a pixel.
REQ-013 i_result_vld / i_result_data  in  1/32  result stream from the blur.
REQ-014 o_result_busy  out  1  driver cannot accept a result.
REQ-015 o_wr_en / o_wr_addr / o_wr_data  out  1/ADDR_W/32  result write port; a write completes in its own cycle.

Function
REQ-016 A pixel transfer SHALL occur on a rising edge where o_rgb_vld=1 and i_rgb_busy=0; a result transfer SHALL occur where i_result_vld=1 and o_result_busy=0.
REQ-017 Once o_rgb_vld is high, o_rgb_vld and o_rgb_data SHALL hold stable until the transfer occurs.
REQ-018 FSM states SHALL be IDLE, RUN, DRAIN and DONE: IDLE->RUN on i_start; RUN->DRAIN when pixel N-1 (N=IMG_W*IMG_H) has transferred; DRAIN->DONE when result N-1 has transferred; DONE->IDLE unconditionally after 1 cycle.
REQ-019 A result MAY arrive in RUN; if result N-1 transfers in the same cycle as pixel N-1, the FSM SHALL go RUN->DONE directly.
REQ-020 Reads SHALL be issued in address order 0..N-1, with o_mem_ren asserted only when (prefetch FIFO occupancy + reads in flight) < 2.
REQ-021 Read data SHALL enter a 2-entry prefetch FIFO; o_rgb_vld SHALL equal FIFO not-empty; o_rgb_data SHALL come from the FIFO head.
REQ-022 With i_rgb_busy held 0, the driver SHALL sustain 1 pixel per cycle after a 2-cycle start latency (i_start at edge k -> first o_rgb_vld at edge k+2).
REQ-023 sof SHALL be 1 only for pixel index 0 and 0 for all other pixels.
REQ-024 o_result_busy SHALL be 0 in RUN and DRAIN and 1 in IDLE and DONE; results are never dropped.
REQ-025 Each accepted result SHALL assert o_wr_en in the same cycle, with o_wr_data=i_result_data and o_wr_addr = the result count (0..N-1).
REQ-026 The pixel counter and result counter SHALL be independent; neither SHALL wrap past N-1 within a frame.
REQ-027 i_start SHALL be ignored in RUN, DRAIN and DONE.
REQ-028 o_done SHALL be high only in DONE.

Reset
REQ-029 Asserting i_rst SHALL immediately force IDLE, flush the FIFO and in-flight tracking, and clear both counters, including mid-frame.
REQ-030 Outputs under reset SHALL be: o_rgb_vld=0, o_rgb_data=0, o_mem_ren=0, o_mem_raddr=0, o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_done=0, o_busy=0, o_result_busy=1.
REQ-031 Read data returning after reset deassertion from a pre-reset request SHALL be discarded.

Structure
REQ-032 The FSM state enum, the 25-bit pixel width, the 32-bit result width and the sof bit position (24) SHALL live in a shared package used by the driver and the blur.
REQ-033 The prefetch FIFO SHALL be a sub-module named blur_prefetch_fifo (depth 2, width 24, with full/empty flags).

Verification
REQ-034 IMG_W=4, IMG_H=2, i_rgb_busy=0, blur model with 3-cycle latency -> 8 pixels on consecutive cycles, sof only on pixel 0; results written to addresses 0..7; one o_done pulse.
REQ-035 i_rgb_busy toggling 1/0 every cycle -> no pixel lost or duplicated; data stable while busy; pixel order 0..7 preserved.
REQ-036 i_rgb_busy held at 1 for 10 cycles mid-frame -> o_mem_ren stops after FIFO occupancy + in-flight reaches 2; streaming resumes with no gap in the sequence.
REQ-037 i_start pulsed in RUN -> ignored; exactly 8 pixels and 1 o_done for the frame.
REQ-038 i_rst asserted after pixel 3 -> all outputs take their reset values immediately; the next i_start streams from pixel 0 with sof=1.
REQ-039 Last result transfers in the same cycle as the last pixel (blur model with 0 latency) -> FSM goes RUN->DONE and o_done pulses once.
